// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light phase sequencer.
// Phase codes, default phase durations and the phase-order helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_RED    = 2'd2
    } phase_e;

    localparam int DEF_GREEN     = 20;
    localparam int DEF_YELLOW    = 3;
    localparam int DEF_RED       = 20;
    localparam int DEF_GREEN_MIN = 5;

    // GREEN -> YELLOW -> RED -> GREEN; the unused code 3 recovers to RED.
    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        n = PH_RED;
        unique case (p)
            PH_GREEN:  n = PH_YELLOW;
            PH_YELLOW: n = PH_RED;
            PH_RED:    n = PH_GREEN;
            default:   n = PH_RED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/phase_cfg_shadow.sv
// Shadow register for a new duration set offered over valid/ready.
// Ports: clk, rst_n, cfg_valid/cfg_ready handshake, cfg_* offered
// durations, rg_edge (RED->GREEN advance this cycle), apply strobe,
// sh_* captured durations.
module phase_cfg_shadow
    import traffic_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_green,
    input  logic [CNT_W-1:0] cfg_yellow,
    input  logic [CNT_W-1:0] cfg_red,
    input  logic             rg_edge,
    output logic             apply,
    output logic [CNT_W-1:0] sh_green,
    output logic [CNT_W-1:0] sh_yellow,
    output logic [CNT_W-1:0] sh_red
);

    logic             pending_q, pending_d;
    logic [CNT_W-1:0] sh_g_q, sh_g_d;
    logic [CNT_W-1:0] sh_y_q, sh_y_d;
    logic [CNT_W-1:0] sh_r_q, sh_r_d;
    logic             xfer;

    // The shadow is free exactly when nothing is pending, so a transfer
    // and an apply can never coincide: an offer landing on the RED->GREEN
    // edge waits for the following one.
    assign cfg_ready = ~pending_q;
    assign xfer      = cfg_valid & ~pending_q;
    assign apply     = rg_edge & pending_q;

    always_comb begin
        pending_d = pending_q;
        sh_g_d    = sh_g_q;
        sh_y_d    = sh_y_q;
        sh_r_d    = sh_r_q;
        if (apply) begin
            pending_d = 1'b0;
        end else if (xfer) begin
            pending_d = 1'b1;
            sh_g_d    = cfg_green;
            sh_y_d    = cfg_yellow;
            sh_r_d    = cfg_red;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            sh_g_q    <= '0;
            sh_y_q    <= '0;
            sh_r_q    <= '0;
        end else begin
            pending_q <= pending_d;
            sh_g_q    <= sh_g_d;
            sh_y_q    <= sh_y_d;
            sh_r_q    <= sh_r_d;
        end
    end

    assign sh_green  = sh_g_q;
    assign sh_yellow = sh_y_q;
    assign sh_red    = sh_r_q;

endmodule

// File: rtl/light_phase_counter.sv
// Phase sequencer GREEN->YELLOW->RED with programmable per-phase durations.
// Ports: clk, rst_n, tick_en, hold, cfg_valid/cfg_ready, cfg_green/yellow/red,
// ped_req (only when LIGHT_PED_REQ_EN is defined), phase, count, phase_done,
// lamp_g/lamp_y/lamp_r.
// Macro LIGHT_PED_REQ_EN: sticky pedestrian request that cuts green short
// once GREEN_MIN ticks have elapsed.
module light_phase_counter
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GREEN_DEF  = DEF_GREEN,
    parameter int YELLOW_DEF = DEF_YELLOW,
    parameter int RED_DEF    = DEF_RED
`ifdef LIGHT_PED_REQ_EN
   ,parameter int GREEN_MIN  = DEF_GREEN_MIN
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_en,
    input  logic             hold,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_green,
    input  logic [CNT_W-1:0] cfg_yellow,
    input  logic [CNT_W-1:0] cfg_red,
`ifdef LIGHT_PED_REQ_EN
    input  logic             ped_req,
`endif
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] count,
    output logic             phase_done,
    output logic             lamp_g,
    output logic             lamp_y,
    output logic             lamp_r
);

    localparam logic [CNT_W-1:0] G_RST = CNT_W'(GREEN_DEF);
    localparam logic [CNT_W-1:0] Y_RST = CNT_W'(YELLOW_DEF);
    localparam logic [CNT_W-1:0] R_RST = CNT_W'(RED_DEF);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] act_g_q, act_g_d;
    logic [CNT_W-1:0] act_y_q, act_y_d;
    logic [CNT_W-1:0] act_r_q, act_r_d;

    logic             step;
    logic [CNT_W-1:0] dur_sel;
    logic [CNT_W-1:0] last_cnt;
    logic             at_term;
    logic             ped_cut;
    logic             advance;
    logic             rg_edge;
    logic             apply;
    logic [CNT_W-1:0] sh_g, sh_y, sh_r;

    phase_cfg_shadow #(
        .CNT_W (CNT_W)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_green  (cfg_green),
        .cfg_yellow (cfg_yellow),
        .cfg_red    (cfg_red),
        .rg_edge    (rg_edge),
        .apply      (apply),
        .sh_green   (sh_g),
        .sh_yellow  (sh_y),
        .sh_red     (sh_r)
    );

`ifdef LIGHT_PED_REQ_EN
    localparam logic [CNT_W-1:0] G_CUT =
        CNT_W'((GREEN_MIN > 0) ? GREEN_MIN - 1 : 0);

    logic ped_flag_q, ped_flag_d;

    // Clearing on green exit happens first so a request sampled on
    // that very cycle still survives for the next green.
    always_comb begin
        ped_flag_d = ped_flag_q;
        if (advance && phase_q == PH_GREEN) begin
            ped_flag_d = 1'b0;
        end
        if (ped_req) begin
            ped_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_flag_q <= 1'b0;
        end else begin
            ped_flag_q <= ped_flag_d;
        end
    end

    assign ped_cut = (phase_q == PH_GREEN) && ped_flag_q
                   && (count_q >= G_CUT);
`else
    assign ped_cut = 1'b0;
`endif

    always_comb begin
        dur_sel = act_r_q;
        unique case (phase_q)
            PH_GREEN:  dur_sel = act_g_q;
            PH_YELLOW: dur_sel = act_y_q;
            default:   dur_sel = act_r_q;
        endcase
    end

    // A zero duration behaves as one tick, so the terminal count is 0.
    assign last_cnt = (dur_sel == '0) ? '0 : dur_sel - CNT_W'(1);
    assign at_term  = (count_q == last_cnt);
    assign step     = tick_en & ~hold;
    assign advance  = step & (at_term | ped_cut);
    assign rg_edge  = advance & (phase_q == PH_RED);

    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (advance) begin
            phase_d = next_phase(phase_q);
            count_d = '0;
            done_d  = 1'b1;
        end else if (step) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        act_g_d = act_g_q;
        act_y_d = act_y_q;
        act_r_d = act_r_q;
        if (apply) begin
            act_g_d = sh_g;
            act_y_d = sh_y;
            act_r_d = sh_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_RED;
            count_q <= '0;
            done_q  <= 1'b0;
            act_g_q <= G_RST;
            act_y_q <= Y_RST;
            act_r_q <= R_RST;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            done_q  <= done_d;
            act_g_q <= act_g_d;
            act_y_q <= act_y_d;
            act_r_q <= act_r_d;
        end
    end

    assign phase      = phase_q;
    assign count      = count_q;
    assign phase_done = done_q;
    assign lamp_g     = (phase_q == PH_GREEN);
    assign lamp_y     = (phase_q == PH_YELLOW);
    assign lamp_r     = (phase_q == PH_RED);

endmodule
